// File: rtl/queue_tap_sched.sv
// queue_tap_sched: sequences FIR tap reads for the HF and LF sample queues
// over one shared RAM read port and MAC. A round-robin arbiter grants one
// pending channel per burst; each burst walks LEN taps oldest-to-newest,
// wrapping at DEPTH, with MAC framing strobes delayed by RD_LAT.
// Build macro SCHED_STATS_EN adds the ovr_cnt / max_wait statistics ports.
module queue_tap_sched #(
    parameter int DEPTH  = 1536,
    parameter int AW     = 11,
    parameter int HF_LEN = 1531,
    parameter int LF_LEN = 1021,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hf_req,
    input  logic [AW-1:0] hf_base,
    input  logic          lf_req,
    input  logic [AW-1:0] lf_base,
    output logic [AW-1:0] raddr,
    output logic          rsel,
    output logic [AW-1:0] coeff_addr,
    output logic          tap_vld,
    output logic          tap_first,
    output logic          tap_last,
    output logic          tap_ch,
    output logic          busy,
    output logic          hf_done,
    output logic          lf_done,
    output logic          overrun
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]   ovr_cnt,
    output logic [15:0]   max_wait
`endif
);

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] HF_LAST   = AW'(HF_LEN - 1);
    localparam logic [AW-1:0] LF_LAST   = AW'(LF_LEN - 1);
    localparam logic [1:0]    DRAIN_END = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t          state, state_nx;
    logic            pend_hf, pend_lf;
    logic [AW-1:0]   base_hf, base_lf;
    logic            rr_last;
    logic [AW-1:0]   idx;
    logic [1:0]      dcnt;
    logic            grant, grant_ch, drain_end;
    logic            pick_lf, any_pend;
    logic [AW-1:0]   last_idx;
    logic            at_last;
    logic [AW:0]     raddr_inc;
    logic [AW-1:0]   raddr_wrap;
    logic            ovr_hf_ev, ovr_lf_ev;
    logic            grant_hf, grant_lf;
    logic [3:0]      a_strb;
    logic [RD_LAT-1:0][3:0] pipe;

    // Out-of-contract pointers (>= DEPTH) are folded back once.
    function automatic logic [AW-1:0] fold_base(input logic [AW-1:0] b);
        if ({1'b0, b} >= DEPTH_W)
            return AW'({1'b0, b} - DEPTH_W);
        return b;
    endfunction

    assign any_pend   = pend_hf | pend_lf;
    assign pick_lf    = ~pend_hf | (pend_lf & ~rr_last);
    assign last_idx   = rsel ? LF_LAST : HF_LAST;
    assign at_last    = (idx == last_idx);
    assign raddr_inc  = {1'b0, raddr} + 1'b1;
    assign raddr_wrap = (raddr_inc == DEPTH_W) ? '0 : raddr_inc[AW-1:0];
    assign grant_hf   = grant & ~grant_ch;
    assign grant_lf   = grant & grant_ch;
    // A request landing on the edge that consumes its channel's pending
    // window starts a fresh window rather than overrunning it.
    assign ovr_hf_ev  = hf_req & pend_hf & ~grant_hf;
    assign ovr_lf_ev  = lf_req & pend_lf & ~grant_lf;
    assign busy       = (state != S_IDLE);
    assign coeff_addr = idx;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state and grant decision; DRAIN exit may grant directly.
    always_comb begin
        state_nx  = state;
        grant     = 1'b0;
        grant_ch  = 1'b0;
        drain_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_pend) begin
                    grant    = 1'b1;
                    grant_ch = pick_lf;
                    state_nx = S_BURST;
                end
            end
            S_BURST: begin
                if (at_last) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (dcnt == DRAIN_END) begin
                    drain_end = 1'b1;
                    if (any_pend) begin
                        grant    = 1'b1;
                        grant_ch = pick_lf;
                        state_nx = S_BURST;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Request capture, arbitration bookkeeping and address walk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_hf <= 1'b0;
            pend_lf <= 1'b0;
            base_hf <= '0;
            base_lf <= '0;
            rr_last <= 1'b1;
            idx     <= '0;
            raddr   <= '0;
            rsel    <= 1'b0;
            dcnt    <= '0;
            overrun <= 1'b0;
            hf_done <= 1'b0;
            lf_done <= 1'b0;
        end else begin
            pend_hf <= hf_req | (pend_hf & ~grant_hf);
            pend_lf <= lf_req | (pend_lf & ~grant_lf);
            if (hf_req) base_hf <= fold_base(hf_base);
            if (lf_req) base_lf <= fold_base(lf_base);
            if (ovr_hf_ev | ovr_lf_ev) overrun <= 1'b1;
            hf_done <= drain_end & ~rsel;
            lf_done <= drain_end & rsel;
            dcnt    <= (state == S_DRAIN && !drain_end) ? dcnt + 2'd1 : '0;
            if (grant) begin
                rr_last <= grant_ch;
                rsel    <= grant_ch;
                raddr   <= grant_ch ? base_lf : base_hf;
                idx     <= '0;
            end else if (state == S_BURST && !at_last) begin
                idx   <= idx + 1'b1;
                raddr <= raddr_wrap;
            end
        end
    end

    assign a_strb = {state == S_BURST,
                     state == S_BURST && idx == '0,
                     state == S_BURST && at_last,
                     rsel};
    assign {tap_vld, tap_first, tap_last, tap_ch} = pipe[RD_LAT-1];

    if (RD_LAT == 1) begin : g_pipe1
        // Single-stage delay of the address-phase strobes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) pipe <= '0;
            else        pipe <= a_strb;
        end
    end else begin : g_pipen
        // RD_LAT-stage shift of the address-phase strobes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) pipe <= '0;
            else        pipe <= {pipe[RD_LAT-2:0], a_strb};
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] wait_hf, wait_lf, g_wait;
    logic [16:0] ovr_sum;

    assign g_wait  = grant_ch ? wait_lf : wait_hf;
    assign ovr_sum = {1'b0, ovr_cnt} + 17'(ovr_hf_ev) + 17'(ovr_lf_ev);

    // Saturating overrun count and worst-case request-to-grant wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt  <= '0;
            max_wait <= '0;
            wait_hf  <= '0;
            wait_lf  <= '0;
        end else begin
            ovr_cnt <= ovr_sum[16] ? '1 : ovr_sum[15:0];
            if (grant && g_wait > max_wait) max_wait <= g_wait;
            if (hf_req)                          wait_hf <= 16'd1;
            else if (pend_hf && wait_hf != '1)   wait_hf <= wait_hf + 16'd1;
            if (lf_req)                          wait_lf <= 16'd1;
            else if (pend_lf && wait_lf != '1)   wait_lf <= wait_lf + 16'd1;
        end
    end
`endif

endmodule

// File: doc/queue_tap_sched.md
Name: queue_tap_sched

Overview:
- Sequences FIR tap reads out of the two sample circular queues: high-frequency (HF) and low-frequency (LF).
- Both queues share one dual-port RAM read path and one MAC.
- On each sample-written strobe from a queue that is sequencing, the block owns the shared read port for one burst.
- A burst walks the queue window oldest-to-newest, wraps at DEPTH, and issues the matching coefficient address plus MAC framing strobes.
- A round-robin arbiter decides which pending channel owns the read port.

Parameters:
- DEPTH, 1536, physical entries per queue; address wrap modulus.
- AW, 11, address width of raddr, base and coeff_addr.
- HF_LEN, 1531, taps per HF burst (1..DEPTH).
- LF_LEN, 1021, taps per LF burst (1..DEPTH).
- RD_LAT, 1, RAM read latency in clk cycles (1..3); tap strobes are delayed by this amount.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- hf_req  in  1  single-cycle strobe: HF queue wrote a sample and is sequencing
- hf_base  in  AW  HF oldest pointer; captured when hf_req=1
- lf_req  in  1  single-cycle strobe, LF queue
- lf_base  in  AW  LF oldest pointer; captured when lf_req=1
- raddr  out  AW  shared RAM read address, registered
- rsel  out  1  read-port select: 0=HF, 1=LF
- coeff_addr  out  AW  coefficient ROM address = tap index
- tap_vld  out  1  RAM data valid for MAC this cycle
- tap_first  out  1  with tap_vld: first tap (MAC clear-and-load)
- tap_last  out  1  with tap_vld: last tap
- tap_ch  out  1  channel of the current tap (0=HF, 1=LF)
- busy  out  1  FSM not IDLE
- hf_done  out  1  1-cycle pulse: HF burst complete
- lf_done  out  1  1-cycle pulse: LF burst complete
- overrun  out  1  sticky: a request arrived while the same channel was already pending

Behaviour:
- Reset values: all outputs 0; raddr=0; coeff_addr=0; FSM=IDLE; both pending=0; rr_last=LF, so HF wins the first tie.
- Request capture:
  - A req at edge k sets pend_x and latches base_x.
  - A req while pend_x=1 re-latches base_x (newest window wins) and sets overrun.
  - A req for the channel currently in BURST sets pend_x normally, so the next window is served after the current one.
- FSM states:
  - IDLE: if any pend_x, grant and go to BURST.
    - Both pending: grant the channel != rr_last.
    - On grant: clear pend_x, set rr_last=granted, idx=0, raddr=base_x, rsel=x.
    - Grant happens at edge k+1 for a req at edge k; a req and a grant in the same cycle never conflict, because pend is written before it is evaluated.
  - BURST: each cycle idx++ and raddr=(raddr+1==DEPTH)?0:raddr+1; coeff_addr=idx.
    - After LEN_x addresses have been issued, go to DRAIN.
  - DRAIN: hold for RD_LAT cycles, then go to IDLE and pulse x_done in the first IDLE cycle.
  - A new grant may occur on that same edge out of IDLE.
- Tap strobes:
  - tap_vld/first/last/ch are the address-phase strobes delayed RD_LAT cycles through a shift pipe.
  - tap_first coincides with idx=0; tap_last with idx=LEN_x-1.
  - Exactly LEN_x tap_vld cycles per burst, contiguous, no gaps.
- Wrap: the address sum is computed at AW+1 bits and compared against DEPTH, never a power of two. base_x >= DEPTH is out of contract; it is reduced once by subtracting DEPTH.
- rsel and raddr are held stable between bursts (last values); tap_vld=0 while idle.
- busy=1 from the grant edge through the end of DRAIN.
- Reset mid-burst: immediate return to the reset state.
  - Pipe strobes are cleared, so no tap_vld, tap_last or done is produced after reset deasserts.
  - Pending requests are lost.

Optional Feature:
- Macro: SCHED_STATS_EN.
- Defined: adds output ports ovr_cnt (16 bits) and max_wait (16 bits).
  - ovr_cnt is a saturating count of overrun events.
  - max_wait is a saturating maximum of the cycles between a req and its grant.
  - Both reset to 0.
- Undefined: the ports are absent; overrun stays sticky only; other behaviour is identical.

Test Plan:
- HF only (DEPTH=1536, HF_LEN=1531, RD_LAT=1): hf_req with hf_base=0 at edge 0 →
  - raddr=0 at edge 1;
  - tap_vld for 1531 cycles from edge 2, tap_first at edge 2, tap_last at edge 1532;
  - hf_done at edge 1533; tap_ch=0.
- Wrap: hf_base=1530 → raddr runs 1530, 1531 … 1535, 0, 1 …; the last address issued is 1524; coeff_addr runs 0..1530.
- Simultaneous requests after reset: hf_req and lf_req in the same cycle → HF burst first, LF granted at the edge that pulses hf_done.
  - A second simultaneous pair → HF again, because rr_last=LF after the LF burst.
- Overrun: lf_req twice before its grant, with base 100 then 200 → one LF burst starting at raddr=200; overrun=1.
- Reset mid-burst: rst_n low for 2 cycles at tap 500 of an HF burst → all outputs 0, no hf_done, no tap_last; the next hf_req is served normally.
- RD_LAT=3: tap_vld lags raddr by exactly 3 cycles, and done follows the last tap by 1 cycle.
